fast_mem_arbiter: RTL

Single-port frame-SRAM arbiter shared by three requesters of the corner-detection pipeline: the Gaussian-blur writer, the FAST segment-test reader and the circle/orientation reader. It grants one access per cycle, issues a registered memory command, and routes read data back to the owning requester through a latency-matched tag pipeline. Optionally it holds a grant across locked bursts, such as the 16-pixel Bresenham circle fetch. It sits between the pipeline controller's datapath units and the frame SRAM macro.

---
 rtl/fast_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/fast_mem_arbiter.sv
// Frame-SRAM arbiter for gaus/fast/circ requesters with locked bursts and read-data tag routing.
// Latency: grant same cycle as req, mem_* command next cycle, *_rvalid RD_LAT cycles after mem_en.
// Backpressure: a requester holds req/addr/wdata until its *_gnt; one access is granted per cycle.
//
// Ports:
//   clk, n_rst                  clock, asynchronous active-low reset
//   gaus_req/we/addr/wdata      Gaussian writer (read with we=0 returns no rvalid), gaus_gnt
//   fast_req/lock/addr          FAST reader, fast_gnt, fast_rvalid
//   circ_req/lock/addr          circle reader, circ_gnt, circ_rvalid
//   rdata                       shared read data, qualified by *_rvalid
//   mem_en/we/addr/wdata        registered SRAM command, mem_rdata returns RD_LAT later
//
// Build option: define ARB_GAUS_PRIO_EN to give gaus_req strict priority, including
// pre-emption of a locked burst (the owner's lock count is frozen while pre-empted).
// Without it, arbitration is a plain three-way round-robin.

`timescale 1ns/1ps

module fast_mem_arbiter #(
   parameter int ADDR_W   = 18,
   parameter int DATA_W   = 8,
   parameter int RD_LAT   = 1,
   parameter int LOCK_MAX = 16
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              gaus_req,
   input  logic              gaus_we,
   input  logic [ADDR_W-1:0] gaus_addr,
   input  logic [DATA_W-1:0] gaus_wdata,
   output logic              gaus_gnt,
   input  logic              fast_req,
   input  logic              fast_lock,
   input  logic [ADDR_W-1:0] fast_addr,
   output logic              fast_gnt,
   output logic              fast_rvalid,
   input  logic              circ_req,
   input  logic              circ_lock,
   input  logic [ADDR_W-1:0] circ_addr,
   output logic              circ_gnt,
   output logic              circ_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int               CNT_W      = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);
   localparam logic [1:0]       ID_GAUS    = 2'd0;
   localparam logic [1:0]       ID_FAST    = 2'd1;
   localparam logic [1:0]       ID_CIRC    = 2'd2;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } state_t;

   // rr_ptr only ever holds 0..2
   function automatic logic [1:0] rr_next(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Returns {found, index}: first asserted request scanning from p upward, wrapping at 3.
   function automatic logic [2:0] rr_pick(input logic [3:0] rq, input logic [1:0] p);
      logic [1:0] c0;
      logic [1:0] c1;
      logic [1:0] c2;
      c0 = p;
      c1 = rr_next(c0);
      c2 = rr_next(c1);
      if (rq[c0])
         return {1'b1, c0};
      else if (rq[c1])
         return {1'b1, c1};
      else if (rq[c2])
         return {1'b1, c2};
      return 3'b000;
   endfunction

   state_t            state, state_nxt;
   logic [1:0]        rr_ptr, rr_nxt;
   logic [1:0]        owner, owner_nxt;
   logic [CNT_W-1:0]  lock_cnt, cnt_nxt;

   logic [3:0]        req_vec;
   logic              owner_req;
   logic              owner_lock;
   logic              own_hold;
   logic              others_pending;

   logic              gnt_any;
   logic [1:0]        gnt_id;
   logic              gnt_vld;
   logic              arb_en;
   logic [3:0]        arb_mask;
   logic [2:0]        pick;
   logic              sel_lock;
   logic [ADDR_W-1:0] sel_addr;

   // Tag pipeline: stage k is visible k+1 cycles after the grant that pushed it,
   // so the tail (stage RD_LAT) lines up with mem_rdata.
   logic [RD_LAT:0]       tag_vld;
   logic [RD_LAT:0][1:0]  tag_id;

   assign req_vec        = {1'b0, circ_req, fast_req, gaus_req};
   assign owner_req      = (owner == ID_CIRC) ? circ_req  : fast_req;
   assign owner_lock     = (owner == ID_CIRC) ? circ_lock : fast_lock;
   assign own_hold       = owner_req & owner_lock;
   assign others_pending = |(req_vec & ~(4'b0001 << owner));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = lock_cnt;
      owner_nxt = owner;
      rr_nxt    = rr_ptr;
      gnt_any   = 1'b0;
      gnt_id    = ID_GAUS;
      arb_en    = 1'b1;
      arb_mask  = 4'b0000;
      pick      = 3'b000;
      sel_lock  = 1'b0;

      if (state == LOCKED) begin
         if (own_hold && (lock_cnt < LOCK_MAX_C)) begin
            arb_en = 1'b0;
`ifdef ARB_GAUS_PRIO_EN
            if (gaus_req) begin
               // pre-empt: owner keeps the lock, count frozen
               gnt_any = 1'b1;
               gnt_id  = ID_GAUS;
            end else begin
               gnt_any = 1'b1;
               gnt_id  = owner;
               cnt_nxt = lock_cnt + CNT_W'(1);
            end
`else
            gnt_any = 1'b1;
            gnt_id  = owner;
            cnt_nxt = lock_cnt + CNT_W'(1);
`endif
         end else begin
            // Lock released or exhausted: arbitrate in this same cycle so there is no bubble.
            state_nxt = ARB;
            cnt_nxt   = '0;
            if (own_hold && others_pending)
               arb_mask = 4'b0001 << owner;
         end
      end

      if (arb_en) begin
`ifdef ARB_GAUS_PRIO_EN
         if (gaus_req) begin
            gnt_any = 1'b1;
            gnt_id  = ID_GAUS;
         end else begin
            pick    = rr_pick(req_vec & ~arb_mask & 4'b0110, rr_ptr);
            gnt_any = pick[2];
            gnt_id  = pick[1:0];
         end
`else
         pick    = rr_pick(req_vec & ~arb_mask, rr_ptr);
         gnt_any = pick[2];
         gnt_id  = pick[1:0];
`endif
         sel_lock = (gnt_id == ID_CIRC) ? circ_lock : fast_lock;
         if (gnt_any && (gnt_id != ID_GAUS) && sel_lock) begin
            state_nxt = LOCKED;
            owner_nxt = gnt_id;
            cnt_nxt   = CNT_W'(1);
         end
      end

`ifdef ARB_GAUS_PRIO_EN
      // Gaussian grants do not disturb the fast/circ rotation.
      if (gnt_any && (gnt_id != ID_GAUS))
         rr_nxt = rr_next(gnt_id);
`else
      if (gnt_any)
         rr_nxt = rr_next(gnt_id);
`endif
   end

   // Grants are combinational; forcing them low under reset keeps every output quiet.
   assign gnt_vld  = gnt_any & n_rst;
   assign gaus_gnt = gnt_vld && (gnt_id == ID_GAUS);
   assign fast_gnt = gnt_vld && (gnt_id == ID_FAST);
   assign circ_gnt = gnt_vld && (gnt_id == ID_CIRC);

   always_comb begin
      sel_addr = gaus_addr;
      case (gnt_id)
         ID_FAST: sel_addr = fast_addr;
         ID_CIRC: sel_addr = circ_addr;
         default: sel_addr = gaus_addr;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= ARB;
         rr_ptr   <= 2'd0;
         owner    <= ID_FAST;
         lock_cnt <= '0;
      end else begin
         state    <= state_nxt;
         rr_ptr   <= rr_nxt;
         owner    <= owner_nxt;
         lock_cnt <= cnt_nxt;
      end
   end

   // Command register. Address/data hold when idle; wdata only moves on Gaussian grants
   // since the readers have no write data of their own.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_en <= gnt_vld;
         mem_we <= gnt_vld && (gnt_id == ID_GAUS) && gaus_we;
         if (gnt_vld)
            mem_addr <= sel_addr;
         if (gnt_vld && (gnt_id == ID_GAUS))
            mem_wdata <= gaus_wdata;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         tag_vld <= '0;
         tag_id  <= '0;
      end else begin
         // Gaussian reads are not tagged: their data is dropped.
         tag_vld[0] <= gnt_vld && (gnt_id != ID_GAUS);
         tag_id[0]  <= gnt_id;
         for (int k = 1; k <= RD_LAT; k++) begin
            tag_vld[k] <= tag_vld[k-1];
            tag_id[k]  <= tag_id[k-1];
         end
      end
   end

   assign fast_rvalid = tag_vld[RD_LAT] && (tag_id[RD_LAT] == ID_FAST);
   assign circ_rvalid = tag_vld[RD_LAT] && (tag_id[RD_LAT] == ID_CIRC);
   assign rdata       = mem_rdata;

endmodule
